// File: rtl/cluster_clock_divider.sv
// cluster_clock_divider: per-channel clock divider with glitch-free ratio changes and a latch-gated bypass
module cluster_clock_divider #(
  parameter int NUM_CLK     = 1,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           test_mode_i,
  input  logic [NUM_CLK-1:0]             en_i,
  input  logic [NUM_CLK*DIV_WIDTH-1:0]   div_i,
  input  logic [NUM_CLK-1:0]             div_valid_i,
  output logic [NUM_CLK-1:0]             div_ready_o,
  output logic [NUM_CLK-1:0]             clk_o
);
  typedef enum logic {IDLE, PENDING} state_e;
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH:0] ONE_W = (DIV_WIDTH+1)'(1);
  for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
    state_e state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_pend, cnt;
    logic [DIV_WIDTH:0] half;
    logic clk_div_q, run_q, en_q, rdy_q, clk_en_l;
    logic bypass, last, accept, apply;
    assign bypass = div_q < DIV_WIDTH'(2);
    assign last = cnt == div_q - ONE;
    assign half = ({1'b0, div_q} + ONE_W) >> 1;
    assign div_ready_o[g] = rdy_q && state_q == IDLE;
    assign accept = div_valid_i[g] && div_ready_o[g];
    // a stopped or bypassed channel has no phase to protect, so it may switch at once
    assign apply = state_q == PENDING && (bypass || !run_q || last);
    always_comb state_d = state_q == IDLE ? (accept ? PENDING : IDLE) : (apply ? IDLE : PENDING);
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q   <= IDLE;
        div_q     <= DIV_WIDTH'(DEFAULT_DIV);
        div_pend  <= '0;
        cnt       <= '0;
        clk_div_q <= 1'b0;
        run_q     <= 1'b0;
        en_q      <= 1'b0;
        rdy_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        rdy_q   <= 1'b1;
        en_q    <= en_i[g];
        if (accept) div_pend <= div_i[g*DIV_WIDTH +: DIV_WIDTH];
        if (bypass) begin
          cnt       <= '0;
          clk_div_q <= 1'b0;
          run_q     <= 1'b0;
        end else if (run_q) begin
          clk_div_q <= {1'b0, cnt} < half;
          cnt       <= last ? '0 : cnt + ONE;
          if (last) run_q <= en_i[g];
        end else begin
          clk_div_q <= 1'b0;
          cnt       <= '0;
          run_q     <= en_i[g];
        end
        if (apply) begin
          div_q <= div_pend;
          cnt   <= '0;
        end
      end
    end
    // tc_clk_gating: enable is captured while clk_i is low so the gated clock never glitches
    always_latch if (!clk_i) clk_en_l <= en_q;
    assign clk_o[g] = test_mode_i ? clk_i : bypass ? (clk_i & clk_en_l) : clk_div_q;
  end
endmodule

// File: doc/cluster_clock_divider.md
CLUSTER_CLOCK_DIVIDER -- requirements
Module: cluster_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CLK, default 1: number of independent divided clock channels.
REQ-002 SHALL have parameter DIV_WIDTH, default 8: width of each divide-ratio value.
REQ-003 SHALL have parameter DEFAULT_DIV, default 1: divide ratio loaded at reset; values 0 or 1 mean bypass.
REQ-004 SHALL have port clk_i, input, 1: single source clock; all logic clocked on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port test_mode_i, input, 1: forces every clk_o[n] to clk_i combinationally.
REQ-007 SHALL have port en_i, input, NUM_CLK: per-channel run enable.
REQ-008 SHALL have port div_i, input, NUM_CLK x DIV_WIDTH: requested divide ratio per channel.
REQ-009 SHALL have port div_valid_i, input, NUM_CLK: per-channel ratio-change request valid.
REQ-010 SHALL have port div_ready_o, output, NUM_CLK: per-channel ratio-change request ready.
REQ-011 SHALL have port clk_o, output, NUM_CLK: per-channel output clock.

Function
REQ-012 Each channel SHALL be independent; the behaviour below applies per channel n, with D = active ratio div_q.
REQ-013 Divided mode (D >= 2): counter cnt SHALL count 0..D-1 and wrap to 0; clk_div_q is registered and high for cnt in [0, ceil(D/2)-1], low otherwise; period is exactly D clk_i cycles.
REQ-014 The registered output SHALL lag cnt by one clk_i cycle; clk_o[n] = clk_div_q in divided mode.
REQ-015 Bypass mode (D <= 1): clk_o[n] SHALL be clk_i gated by a latch-based clock gate (tc_clk_gating) whose enable is en_i registered; cnt and clk_div_q are held at 0.
REQ-016 test_mode_i=1 SHALL override all modes with clk_o[n] = clk_i, with no effect on internal state.
REQ-017 Handshake FSM states SHALL be IDLE and PENDING; div_ready_o=1 only in IDLE.
REQ-018 IDLE: on div_valid_i & div_ready_o, capture div_i into div_pend and go to PENDING next cycle.
REQ-019 PENDING: apply div_pend to div_q at the next safe boundary, reset cnt to 0, and return to IDLE in the same cycle.
REQ-020 Safe boundary (divided mode) SHALL be the cycle with cnt = D-1, which is the last low cycle; a new period starts high on the next cycle.
REQ-021 Safe boundary (bypass mode, or divided mode with channel stopped) SHALL be the first cycle in PENDING.
REQ-022 A request with the same value as div_q SHALL still complete the handshake, with no disturbance to clk_o.
REQ-023 en_i falling in divided mode SHALL let the current period finish at cnt = D-1, then hold cnt=0 and clk_div_q=0; no truncated high pulse is allowed.
REQ-024 en_i rising while stopped SHALL start cnt at 0 on the next cycle; the first high phase has full length.
REQ-025 The minimum high or low phase of clk_o in divided mode SHALL never be shorter than floor(D/2) clk_i cycles for the old or new D.
REQ-026 div_valid_i deasserting while in PENDING SHALL have no effect; once accepted, a request always completes.

Reset
REQ-027 With rst_ni=0 at a rising clk_i edge, the block SHALL set div_q=DEFAULT_DIV, cnt=0, clk_div_q=0, FSM=IDLE, and clock-gate enable=0.
REQ-028 div_ready_o SHALL be 0 while rst_ni=0.
REQ-029 A reset arriving in PENDING SHALL discard div_pend.
REQ-030 No output SHALL depend asynchronously on rst_ni.

Verification
REQ-031 Reset with DEFAULT_DIV=1, en_i=1 -> clk_o follows clk_i after the gate enable registers; div_ready_o=1 from the first cycle after reset release.
REQ-032 Request div=4, en=1 -> handshake completes; clk_o gives 2 cycles high and 2 low, repeating; request div=5 -> 3 high and 2 low, switched only after a low phase.
REQ-033 D=6 running, request div=2 issued at cnt=1 -> the current 6-cycle period completes, then 1 high and 1 low; div_ready_o is low for the whole wait.
REQ-034 D=4, en_i dropped at cnt=0 -> high phase completes (2 cycles), low phase completes, then clk_o stays 0; en_i rising -> next cycle starts a full 2-cycle high phase.
REQ-035 NUM_CLK=2, channel 0 at div 3 and channel 1 at div 8 with simultaneous requests -> each channel switches at its own boundary with no cross-effect.
REQ-036 rst_ni pulsed low while PENDING, and test_mode_i=1 at any time -> reset gives div_q=DEFAULT_DIV with no stale ratio applied; test mode gives clk_o=clk_i on all channels.
